// File: rtl/full_adder_4b_pkg.sv
// Shared display constants and the binary-to-BCD helpers for the 4-bit adder board block.
`timescale 1ns/1ps
package full_adder_4b_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;

  // The sum never exceeds 31, so a three-step compare replaces a divider.
  function automatic logic [3:0] bcd_tens(input logic [4:0] v);
    if (v >= 5'd30)      return 4'd3;
    else if (v >= 5'd20) return 4'd2;
    else if (v >= 5'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [4:0] v);
    logic [4:0] r;
    if (v >= 5'd30)      r = v - 5'd30;
    else if (v >= 5'd20) r = v - 5'd20;
    else if (v >= 5'd10) r = v - 5'd10;
    else                 r = v;
    return r[3:0];
  endfunction

endpackage

// File: rtl/full_adder_4b_seg7_decoder.sv
// BCD digit to active-low 7-segment pattern (g..a); non-decimal codes blank the digit.
`timescale 1ns/1ps
module seg7_decoder
  import full_adder_4b_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK[6:0];
    case (bcd_i)
      4'd0: seg_o = SEG_0[6:0];
      4'd1: seg_o = SEG_1[6:0];
      4'd2: seg_o = SEG_2[6:0];
      4'd3: seg_o = SEG_3[6:0];
      4'd4: seg_o = SEG_4[6:0];
      4'd5: seg_o = SEG_5[6:0];
      4'd6: seg_o = SEG_6[6:0];
      4'd7: seg_o = SEG_7[6:0];
      4'd8: seg_o = SEG_8[6:0];
      4'd9: seg_o = SEG_9[6:0];
      default: seg_o = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/full_adder_4b.sv
// 4-bit adder with decimal result on a multiplexed 7-segment display; carry-out
// lights the decimal point of the ones digit.
`timescale 1ns/1ps
module full_adder_4b
  import full_adder_4b_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [7:0] sseg,
  output logic [3:0] AN
);

  logic [4:0] sum;
  logic       cout;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] tens_seg;
  logic [6:0] ones_seg;
  logic [1:0] slot;

  // Initialisers match the reset values so the display is sane without a reset pulse.
  logic [REFRESH_BITS-1:0] cnt_q = '0;
  logic [REFRESH_BITS-1:0] cnt_d;
  logic [7:0]              sseg_q = SEG_BLANK;
  logic [7:0]              sseg_d;
  logic [3:0]              an_q = AN_OFF;
  logic [3:0]              an_d;

  assign sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign cout = sum[4];
  assign tens = bcd_tens(sum);
  assign ones = bcd_ones(sum);

  seg7_decoder u_dec_ones (.bcd_i(ones), .seg_o(ones_seg));
  seg7_decoder u_dec_tens (.bcd_i(tens), .seg_o(tens_seg));

  assign slot  = cnt_q[REFRESH_BITS-1 -: 2];
  assign cnt_d = cnt_q + 1'b1;

  always_comb begin
    an_d   = AN_OFF;
    sseg_d = SEG_BLANK;
    case (slot)
      2'd0: begin
        an_d   = AN_ONES;
        sseg_d = {~cout, ones_seg};
      end
      2'd1: begin
        // Leading zero in the tens position stays dark.
        if (tens != 4'd0) begin
          an_d   = AN_TENS;
          sseg_d = {1'b1, tens_seg};
        end
      end
      default: begin
        an_d   = AN_OFF;
        sseg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      an_q   <= AN_OFF;
      sseg_q <= SEG_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign sseg = sseg_q;
  assign AN   = an_q;

endmodule

// File: tb/tb_full_adder_4b.sv
// Bench for full_adder_4b with a short refresh counter so every digit slot is visited.
`timescale 1ns/1ps
module tb_full_adder_4b;

  localparam int RB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       cin = 1'b0;
  logic [7:0] sseg;
  logic [3:0] AN;

  int n_chk = 0;
  int n_err = 0;

  full_adder_4b #(.REFRESH_BITS(RB)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .cin(cin), .sseg(sseg), .AN(AN)
  );

  always #10 clk = ~clk;

  // Reference: decimal digits by plain division, glyphs from a lookup table.
  logic [7:0] glyph [10];
  initial begin
    glyph[0] = 8'hC0; glyph[1] = 8'hF9; glyph[2] = 8'hA4; glyph[3] = 8'hB0;
    glyph[4] = 8'h99; glyph[5] = 8'h92; glyph[6] = 8'h82; glyph[7] = 8'hF8;
    glyph[8] = 8'h80; glyph[9] = 8'h90;
  end

  function automatic logic [11:0] model_out(input int av, input int bv, input int cv, input int sl);
    int s;
    int t;
    int o;
    logic [7:0] g;
    s = av + bv + cv;
    t = s / 10;
    o = s % 10;
    if (sl == 0) begin
      g = glyph[o];
      if (s >= 16) g[7] = 1'b0;
      return {4'b1110, g};
    end else if (sl == 1 && t != 0) begin
      return {4'b1101, glyph[t]};
    end
    return {4'b1111, 8'hFF};
  endfunction

  int         mcnt = 0;
  logic [11:0] mexp = {4'b1111, 8'hFF};

  always @(posedge clk) begin
    if (reset) begin
      mcnt <= 0;
      mexp <= {4'b1111, 8'hFF};
    end else begin
      mexp <= model_out(int'(a), int'(b), int'(cin), (mcnt / (1 << (RB - 2))) % 4);
      mcnt <= (mcnt + 1) % (1 << RB);
    end
  end

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got AN/sseg=%h required %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic        cin;
    logic [11:0] s0;
    logic [11:0] s1;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{4'd0,  4'd1,  1'b0, 12'hEF9, 12'hFFF};
    tbl[1] = '{4'd3,  4'd2,  1'b0, 12'hE92, 12'hFFF};
    tbl[2] = '{4'd13, 4'd3,  1'b0, 12'hE02, 12'hDF9};
    tbl[3] = '{4'd15, 4'd15, 1'b1, 12'hE79, 12'hDB0};
    tbl[4] = '{4'd4,  4'd4,  1'b0, 12'hE80, 12'hFFF};
    tbl[5] = '{4'd9,  4'd0,  1'b1, 12'hEC0, 12'hDF9};

    // Reset held for two edges.
    reset = 1'b1;
    cyc(2);
    check("reset_blank", {AN, sseg}, 12'hFFF);

    foreach (tbl[i]) begin
      a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin;
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(1);
      check($sformatf("vec%0d_slot0", i), {AN, sseg}, tbl[i].s0);
      cyc(4);
      check($sformatf("vec%0d_slot1", i), {AN, sseg}, tbl[i].s1);
      cyc(4);
      check($sformatf("vec%0d_slot2", i), {AN, sseg}, 12'hFFF);
      cyc(4);
      check($sformatf("vec%0d_slot3", i), {AN, sseg}, 12'hFFF);
    end

    // Full wrap: slot order 0,1,2,3,0 on the anodes.
    a = 4'd13; b = 4'd3; cin = 1'b0;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    check("wrap_s0", {AN, sseg}, 12'hE02);
    cyc(4);
    check("wrap_s1", {AN, sseg}, 12'hDF9);
    cyc(4);
    check("wrap_s2", {AN, sseg}, 12'hFFF);
    cyc(4);
    check("wrap_s3", {AN, sseg}, 12'hFFF);
    cyc(4);
    check("wrap_s0_again", {AN, sseg}, 12'hE02);
    cyc(1);
    check("wrap_s0_hold", {AN, sseg}, 12'hE02);

    // Reset in the middle of slot 2.
    cyc(8);
    check("mid_s2", {AN, sseg}, 12'hFFF);
    cyc(4);
    check("pre_reset_s3", {AN, sseg}, 12'hFFF);
    reset = 1'b1;
    cyc(1);
    check("reset_in_scan", {AN, sseg}, 12'hFFF);
    reset = 1'b0;
    cyc(1);
    check("resume_s0", {AN, sseg}, 12'hE02);
    cyc(3);
    check("resume_s0_end", {AN, sseg}, 12'hE02);
    cyc(1);
    check("resume_s1", {AN, sseg}, 12'hDF9);

    // Input change mid-slot shows up on the next edge.
    a = 4'd7; b = 4'd7; cin = 1'b1;
    cyc(1);
    check("live_change", {AN, sseg}, 12'hDF9);
    a = 4'd2; b = 4'd1; cin = 1'b0;
    cyc(1);
    check("live_blank_tens", {AN, sseg}, 12'hFFF);

    // Random operands and occasional reset against the reference model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        cin = 1'($urandom_range(0, 1));
      end
      reset = ($urandom_range(0, 39) == 0);
      cyc(1);
      check($sformatf("rand%0d", k), {AN, sseg}, mexp);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
